// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl: pipeline stall/flush control with per-register          |
// | countdown scoreboard; HAZARD_CTRL_FORWARD_EN selects load-use only.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_ctrl #(
    parameter int REG_W   = 5,
    parameter int WB_DIST = 2,
    parameter int CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             halt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_wen,
    input  logic             ex_load,
    output logic             stall_ifid,
    output logic             stall_idex,
    output logic             stall_xmem,
    output logic             stall_wb,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             flush_xmem,
    output logic             flush_wb,
    output logic             pc_en,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] S_RUN     = 2'd0;
    localparam logic [1:0] S_MEMWAIT = 2'd1;
    localparam logic [1:0] S_LDSTALL = 2'd2;
    localparam logic [1:0] S_HALTED  = 2'd3;

    localparam int c_NREG = 2 ** REG_W;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             w_memwait;
    logic             w_redirect;
    logic             w_hazard;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_memwait  = (dmemREN | dmemWEN) & ~dhit;
    assign w_redirect = branch_taken | jump;

`ifdef HAZARD_CTRL_FORWARD_EN
    // Forwarding covers everything except a load result needed right away.
    assign w_hazard = ex_load & ex_wen & (ex_rd != '0) &
                      ((id_rs_used & (id_rs == ex_rd)) |
                       (id_rt_used & (id_rt == ex_rd)));
`else
    localparam int c_SB_W = (WB_DIST > 0) ? $clog2(WB_DIST + 1) : 1;
    localparam logic [c_SB_W-1:0] c_SB_LOAD = c_SB_W'(WB_DIST);

    logic [c_NREG-1:0] w_pend;
    logic              w_unused_ok;

    assign w_unused_ok = ex_load;

    for (genvar g = 0; g < c_NREG; g++) begin : g_sb
        if (g == 0) begin : g_zero
            assign w_pend[g] = 1'b0;
        end else begin : g_entry
            logic [c_SB_W-1:0] r_cnt;
            logic              w_hit;

            assign w_hit = ex_wen & (ex_rd == REG_W'(g));

            always_ff @(posedge CLK) begin
                if (RST) begin
                    r_cnt <= '0;
                end else if (w_hit && !stall_xmem) begin
                    r_cnt <= c_SB_LOAD;
                end else if ((r_cnt != '0) && !stall_wb) begin
                    r_cnt <= r_cnt - 1'b1;
                end
            end

            // The instruction in EX is pending before it reaches the scoreboard.
            assign w_pend[g] = (r_cnt != '0) | w_hit;
        end
    end

    assign w_hazard = (id_rs_used & (id_rs != '0) & w_pend[id_rs]) |
                      (id_rt_used & (id_rt != '0) & w_pend[id_rt]);
`endif

    always_comb begin
        stall_ifid  = 1'b0;
        stall_idex  = 1'b0;
        stall_xmem  = 1'b0;
        stall_wb    = 1'b0;
        flush_ifid  = 1'b0;
        flush_idex  = 1'b0;
        flush_xmem  = 1'b0;
        flush_wb    = 1'b0;
        pc_en       = 1'b1;
        w_state_nxt = r_state;
        if (RST) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            flush_xmem  = 1'b1;
            flush_wb    = 1'b1;
            pc_en       = 1'b0;
            w_state_nxt = S_RUN;
        end else if (w_memwait) begin
            stall_ifid  = 1'b1;
            stall_idex  = 1'b1;
            stall_xmem  = 1'b1;
            stall_wb    = 1'b1;
            pc_en       = 1'b0;
            // A halted core stays halted even if a stray access is pending.
            w_state_nxt = (r_state == S_HALTED) ? S_HALTED : S_MEMWAIT;
        end else if (r_state == S_HALTED) begin
            flush_ifid  = 1'b1;
            flush_idex  = 1'b1;
            pc_en       = 1'b0;
        end else begin
            w_state_nxt = S_RUN;
            if (w_redirect) begin
                flush_ifid = 1'b1;
                flush_idex = 1'b1;
            end else if (w_hazard) begin
                stall_ifid  = 1'b1;
                flush_idex  = 1'b1;
                pc_en       = 1'b0;
                w_state_nxt = S_LDSTALL;
            end else if (!ihit) begin
                stall_ifid = 1'b1;
                flush_idex = 1'b1;
                pc_en      = 1'b0;
            end
            if (halt) begin
                w_state_nxt = S_HALTED;
            end
        end
    end

    assign halted = (r_state == S_HALTED) & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_stall_cnt <= '0;
        end else if (!pc_en && (r_state != S_HALTED) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl: directed vector table plus multi-cycle sequences.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;

`ifdef HAZARD_CTRL_FORWARD_EN
    localparam bit SB = 1'b0;
`else
    localparam bit SB = 1'b1;
`endif
    localparam logic [3:0] HZ_ST = SB ? 4'b1000 : 4'b0000;
    localparam logic [3:0] HZ_FL = SB ? 4'b0100 : 4'b0000;
    localparam logic       HZ_PC = SB ? 1'b0 : 1'b1;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, dmemREN, dmemWEN, branch_taken, jump, halt;
    logic [4:0] id_rs, id_rt, ex_rd;
    logic       id_rs_used, id_rt_used, ex_wen, ex_load;
    logic       stall_ifid, stall_idex, stall_xmem, stall_wb;
    logic       flush_ifid, flush_idex, flush_xmem, flush_wb;
    logic       pc_en, halted;
    logic [15:0] stall_cnt;

    logic       ihit_sat;
    logic [3:0] s_stall, s_flush;
    logic       s_pc_en, s_halted;
    logic [3:0] s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    hazard_ctrl u_dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .branch_taken(branch_taken), .jump(jump), .halt(halt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .ex_rd(ex_rd), .ex_wen(ex_wen), .ex_load(ex_load),
        .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_xmem(stall_xmem), .stall_wb(stall_wb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_xmem(flush_xmem), .flush_wb(flush_wb),
        .pc_en(pc_en), .halted(halted), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) u_sat (
        .CLK(CLK), .RST(RST), .ihit(ihit_sat), .dhit(1'b1),
        .dmemREN(1'b0), .dmemWEN(1'b0),
        .branch_taken(1'b0), .jump(1'b0), .halt(1'b0),
        .id_rs(5'd0), .id_rt(5'd0), .id_rs_used(1'b0), .id_rt_used(1'b0),
        .ex_rd(5'd0), .ex_wen(1'b0), .ex_load(1'b0),
        .stall_ifid(s_stall[3]), .stall_idex(s_stall[2]),
        .stall_xmem(s_stall[1]), .stall_wb(s_stall[0]),
        .flush_ifid(s_flush[3]), .flush_idex(s_flush[2]),
        .flush_xmem(s_flush[1]), .flush_wb(s_flush[0]),
        .pc_en(s_pc_en), .halted(s_halted), .stall_cnt(s_cnt)
    );

    typedef struct {
        logic       rst, ih, dh, ren, wen, br, jmp, hlt;
        logic [4:0] rs;
        logic       rsu;
        logic [4:0] rt;
        logic       rtu;
        logic [4:0] rd;
        logic       exw, ld;
        logic [3:0] e_stall, e_flush;
        logic       e_pc, e_halted;
        string      name;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        RST = 1'b0; ihit = 1'b1; dhit = 1'b1; dmemREN = 1'b0; dmemWEN = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; halt = 1'b0;
        id_rs = '0; id_rt = '0; id_rs_used = 1'b0; id_rt_used = 1'b0;
        ex_rd = '0; ex_wen = 1'b0; ex_load = 1'b0;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    function automatic logic [3:0] st4();
        return {stall_ifid, stall_idex, stall_xmem, stall_wb};
    endfunction

    function automatic logic [3:0] fl4();
        return {flush_ifid, flush_idex, flush_xmem, flush_wb};
    endfunction

    initial begin
        int n_st;
        ihit_sat = 1'b1;
        idle();
        RST = 1'b1;

        //          rst ih dh rn wn br jp ht  rs  u   rt  u   rd  w  l  stall    flush    pc h
        vecs[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b1111, 0, 0, "reset"};
        vecs[1]  = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "idle"};
        vecs[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b1000, 4'b0100, 0, 0, "imiss"};
        vecs[3]  = '{0, 0, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b1100, 1, 0, "br_over_imiss"};
        vecs[4]  = '{0, 1, 1, 0, 0, 0, 1, 0, 5'd3, 1, 5'd0, 0, 5'd3, 1, 0, 4'b0000, 4'b1100, 1, 0, "jmp_over_haz"};
        vecs[5]  = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd3, 1, 5'd0, 0, 5'd0, 0, 0, HZ_ST,   HZ_FL,   HZ_PC, 0, "sb_rs_cnt2"};
        vecs[6]  = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd3, 1, 5'd0, 0, 0, HZ_ST,   HZ_FL,   HZ_PC, 0, "sb_rt_cnt1"};
        vecs[7]  = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd3, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "sb_cleared"};
        vecs[8]  = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 1, 5'd0, 0, 5'd0, 1, 0, 4'b0000, 4'b0000, 1, 0, "r0_never"};
        vecs[9]  = '{0, 1, 0, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b1111, 4'b0000, 0, 0, "memwait_wr"};
        vecs[10] = '{0, 1, 1, 0, 1, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "mem_done"};
        vecs[11] = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd5, 0, 5'd0, 0, 5'd5, 1, 0, 4'b0000, 4'b0000, 1, 0, "unused_src"};
        vecs[12] = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd5, 1, 5'd0, 0, 5'd0, 0, 0, HZ_ST,   HZ_FL,   HZ_PC, 0, "sb_after_unused"};
        vecs[13] = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd5, 0, 5'd9, 1, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "other_reg"};
        vecs[14] = '{0, 1, 0, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd6, 1, 0, 4'b1111, 4'b0000, 0, 0, "memwait_noload"};
        vecs[15] = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd6, 1, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "no_load_in_wait"};
        vecs[16] = '{0, 1, 1, 0, 0, 0, 0, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "halt_issue"};
        vecs[17] = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b1100, 0, 1, "halted"};
        vecs[18] = '{0, 1, 1, 0, 0, 1, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b1100, 0, 1, "halt_over_br"};
        vecs[19] = '{1, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b1111, 0, 0, "reset_from_halt"};
        vecs[20] = '{0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 4'b0000, 4'b0000, 1, 0, "post_reset"};

        for (int i = 0; i < 21; i++) begin
            RST = vecs[i].rst; ihit = vecs[i].ih; dhit = vecs[i].dh;
            dmemREN = vecs[i].ren; dmemWEN = vecs[i].wen;
            branch_taken = vecs[i].br; jump = vecs[i].jmp; halt = vecs[i].hlt;
            id_rs = vecs[i].rs; id_rs_used = vecs[i].rsu;
            id_rt = vecs[i].rt; id_rt_used = vecs[i].rtu;
            ex_rd = vecs[i].rd; ex_wen = vecs[i].exw; ex_load = vecs[i].ld;
            @(negedge CLK);
            chk({vecs[i].name, "_stall"}, 32'(st4()), 32'(vecs[i].e_stall));
            chk({vecs[i].name, "_flush"}, 32'(fl4()), 32'(vecs[i].e_flush));
            chk({vecs[i].name, "_pc_en"}, 32'(pc_en), 32'(vecs[i].e_pc));
            chk({vecs[i].name, "_halted"}, 32'(halted), 32'(vecs[i].e_halted));
            step();
        end

        // Dependency on an in-flight write: count stall cycles until the PC moves.
        do_reset();
        chk("cnt_after_reset", 32'(stall_cnt), 32'd0);
        n_st = 0;
`ifdef HAZARD_CTRL_FORWARD_EN
        for (int k = 0; k < 6; k++) begin
            ex_load = (k == 0); ex_wen = (k == 0); ex_rd = 5'd8;
            id_rt = 5'd8; id_rt_used = 1'b1;
            @(negedge CLK);
            if (pc_en) break;
            if (stall_ifid && flush_idex) n_st++;
            step();
        end
        chk("fwd_load_use_stalls", 32'(n_st), 32'd1);
        chk("fwd_load_use_pc_en", 32'(pc_en), 32'd1);
        step();
        ex_load = 1'b0; ex_wen = 1'b1; ex_rd = 5'd8;
        @(negedge CLK);
        chk("fwd_alu_no_stall", 32'(pc_en), 32'd1);
        step();
`else
        for (int k = 0; k < 6; k++) begin
            ex_wen = (k == 0); ex_rd = 5'd8;
            id_rs = 5'd8; id_rs_used = 1'b1;
            @(negedge CLK);
            if (pc_en) break;
            if (stall_ifid && flush_idex) n_st++;
            step();
        end
        chk("sb_dep_stalls", 32'(n_st), 32'd3);
        chk("sb_dep_pc_en", 32'(pc_en), 32'd1);
        chk("sb_dep_stall_cnt", 32'(stall_cnt), 32'd3);
        step();
`endif

        // Memory wait with a pending branch: wait wins, redirect follows on hit.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            dmemREN = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
            @(negedge CLK);
            chk("mw_stall_all", 32'(st4()), 32'hF);
            chk("mw_no_flush", 32'(fl4()), 32'h0);
            step();
        end
        dhit = 1'b1;
        @(negedge CLK);
        chk("mw_hit_stall", 32'(st4()), 32'h0);
        chk("mw_hit_flush", 32'(fl4()), 32'hC);
        chk("mw_hit_pc_en", 32'(pc_en), 32'd1);
        chk("mw_stall_cnt", 32'(stall_cnt), 32'd4);
        step();

        // Halt: sticky, counter frozen, cleared by reset.
        do_reset();
        ihit = 1'b0;
        step();
        ihit = 1'b1; halt = 1'b1;
        @(negedge CLK);
        chk("halt_cycle_halted", 32'(halted), 32'd0);
        chk("halt_cycle_cnt", 32'(stall_cnt), 32'd1);
        step();
        halt = 1'b0; ihit = 1'b0;
        @(negedge CLK);
        chk("halt_next_halted", 32'(halted), 32'd1);
        chk("halt_next_pc_en", 32'(pc_en), 32'd0);
        for (int k = 0; k < 3; k++) step();
        @(negedge CLK);
        chk("halt_cnt_frozen", 32'(stall_cnt), 32'd1);
        chk("halt_sticky", 32'(halted), 32'd1);
        do_reset();
        @(negedge CLK);
        chk("halt_rst_halted", 32'(halted), 32'd0);
        chk("halt_rst_cnt", 32'(stall_cnt), 32'd0);

        // Narrow counter saturation.
        chk("sat_start", 32'(s_cnt), 32'd0);
        ihit_sat = 1'b0;
        for (int k = 0; k < 20; k++) step();
        @(negedge CLK);
        chk("sat_at_15", 32'(s_cnt), 32'd15);
        step();
        @(negedge CLK);
        chk("sat_held", 32'(s_cnt), 32'd15);
        ihit_sat = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
